// File: rtl/accel_eth_frame_packer.sv
// Packs 48-bit accelerometer samples into Ethernet II frames on an 8-bit AXI-Stream.
// Define ACCEL_ETH_FRAME_TS_EN to insert a 32-bit cycle timestamp after the sequence number.
module accel_eth_frame_packer #(
  parameter logic [47:0] DST_MAC           = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC           = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE         = 16'h88B5,
  parameter int unsigned SAMPLES_PER_FRAME = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tkeep
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_SEQ    = 3'd2,
    S_TS     = 3'd3,
    S_LOAD   = 3'd4,
    S_SAMPLE = 3'd5
  } state_t;

  localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [7:0]   LAST_CNT = 8'(SAMPLES_PER_FRAME - 32'd1);

  generate
    if ((SAMPLES_PER_FRAME < 32'd8) || (SAMPLES_PER_FRAME > 32'd240)) begin : g_bad_n
      $error("SAMPLES_PER_FRAME must be within 8..240");
    end
  endgenerate

  state_t      state_q;
  logic [3:0]  byte_idx_q;
  logic [7:0]  sample_cnt_q;
  logic [15:0] seq_q;
  logic [47:0] sample_q;
  logic [7:0]  m_tdata_q;
  logic        m_tvalid_q;
  logic        m_tlast_q;
  logic        s_tready_q;

  // Header byte idx, MSB byte of the destination MAC first.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    logic [6:0] sh;
    sh = 7'd104 - {idx, 3'b000};
    return HDR[sh +: 8];
  endfunction

`ifdef ACCEL_ETH_FRAME_TS_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_q;

  // Free-running cycle counter used as the frame timestamp.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt_q <= 32'd0;
    else       ts_cnt_q <= ts_cnt_q + 32'd1;
  end
`endif

  // Frame state machine; the output registers hold the byte currently presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 4'd0;
      sample_cnt_q <= 8'd0;
      seq_q        <= 16'd0;
      sample_q     <= 48'd0;
      m_tdata_q    <= 8'd0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      s_tready_q   <= 1'b0;
`ifdef ACCEL_ETH_FRAME_TS_EN
      ts_q         <= 32'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (s_tvalid) begin
            state_q    <= S_HDR;
            byte_idx_q <= 4'd0;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= hdr_byte(4'd0);
`ifdef ACCEL_ETH_FRAME_TS_EN
            ts_q       <= ts_cnt_q;
`endif
          end
        end
        S_HDR: begin
          if (m_tready) begin
            if (byte_idx_q == 4'd13) begin
              state_q    <= S_SEQ;
              byte_idx_q <= 4'd0;
              m_tdata_q  <= seq_q[15:8];
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              m_tdata_q  <= hdr_byte(byte_idx_q + 4'd1);
            end
          end
        end
        S_SEQ: begin
          if (m_tready) begin
            if (byte_idx_q == 4'd0) begin
              byte_idx_q <= 4'd1;
              m_tdata_q  <= seq_q[7:0];
            end else begin
              byte_idx_q <= 4'd0;
`ifdef ACCEL_ETH_FRAME_TS_EN
              state_q    <= S_TS;
              m_tdata_q  <= ts_q[31:24];
              ts_q       <= {ts_q[23:0], 8'h00};
`else
              state_q    <= S_LOAD;
              m_tvalid_q <= 1'b0;
              s_tready_q <= 1'b1;
`endif
            end
          end
        end
`ifdef ACCEL_ETH_FRAME_TS_EN
        S_TS: begin
          if (m_tready) begin
            if (byte_idx_q == 4'd3) begin
              state_q    <= S_LOAD;
              byte_idx_q <= 4'd0;
              m_tvalid_q <= 1'b0;
              s_tready_q <= 1'b1;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              m_tdata_q  <= ts_q[31:24];
              ts_q       <= {ts_q[23:0], 8'h00};
            end
          end
        end
`endif
        S_LOAD: begin
          if (s_tvalid) begin
            state_q    <= S_SAMPLE;
            byte_idx_q <= 4'd0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= s_tdata[7:0];
            sample_q   <= {8'h00, s_tdata[47:8]};
          end
        end
        S_SAMPLE: begin
          if (m_tready) begin
            if (byte_idx_q == 4'd5) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              byte_idx_q <= 4'd0;
              if (sample_cnt_q == LAST_CNT) begin
                state_q      <= S_IDLE;
                sample_cnt_q <= 8'd0;
                seq_q        <= seq_q + 16'd1;
              end else begin
                state_q      <= S_LOAD;
                sample_cnt_q <= sample_cnt_q + 8'd1;
                s_tready_q   <= 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              m_tdata_q  <= sample_q[7:0];
              sample_q   <= {8'h00, sample_q[47:8]};
              // tlast rides on byte 5 of the final sample only.
              m_tlast_q  <= (byte_idx_q == 4'd4) && (sample_cnt_q == LAST_CNT);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          byte_idx_q <= 4'd0;
          m_tvalid_q <= 1'b0;
          m_tlast_q  <= 1'b0;
          s_tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready = s_tready_q;
  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tkeep  = 1'b1;

endmodule

// File: tb/tb_accel_eth_frame_packer.sv
// Directed bench for accel_eth_frame_packer (default build: N=8, no timestamp).
module tb_accel_eth_frame_packer;
  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tkeep;

  always #5 clk = ~clk;

  accel_eth_frame_packer dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tkeep(m_tkeep)
  );

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct { int idx; logic [7:0] d; logic l; } vec_t;

  localparam logic [47:0] BASE0 = 48'h0605_0403_0201;
  localparam logic [47:0] BASE1 = 48'h1111_2222_3340;
  localparam logic [47:0] BASE2 = 48'hA0B0_C0D0_E0F0;
  localparam logic [47:0] BASE3 = 48'h0102_0304_0580;

  int          checks = 0;
  int          failures = 0;
  int          stalls = 0;
  bit          rdy_rand = 1'b0;
  beat_t       cap_q[$];
  logic [47:0] src_q[$];
  logic [7:0]  fr_d[0:299];
  logic        fr_l[0:299];
  int          fr_len = 0;
  vec_t        vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] seq, input logic [47:0] base);
    logic [47:0] s;
    int j;
    case (i)
      0, 1, 2, 3, 4, 5: return 8'hFF;
      6:  return 8'h02;
      11: return 8'h01;
      7, 8, 9, 10: return 8'h00;
      12: return 8'h88;
      13: return 8'hB5;
      14: return seq[15:8];
      15: return seq[7:0];
      default: begin
        j = i - 16;
        s = base + 48'(j / 6);
        return s[8*(j % 6) +: 8];
      end
    endcase
  endfunction

  // Output monitor: records transfers and checks that stalled beats hold.
  logic       stall_prev = 1'b0;
  logic [7:0] d_prev;
  logic       l_prev;
  always @(negedge clk) begin
    if (stall_prev && !reset) begin
      checks++;
      if (!m_tvalid || m_tdata !== d_prev || m_tlast !== l_prev) begin
        failures++;
        $display("FAIL stall_hold: got v=%0b d=%02h l=%0b expected v=1 d=%02h l=%0b",
                 m_tvalid, m_tdata, m_tlast, d_prev, l_prev);
      end
    end
    stall_prev = m_tvalid && !m_tready && !reset;
    d_prev = m_tdata;
    l_prev = m_tlast;
    if (m_tvalid && !m_tready) stalls++;
    if (m_tvalid && m_tready && !reset) cap_q.push_back({m_tdata, m_tlast});
  end

  // Sample source and sink-ready driver, updated 1 ns after each rising edge.
  initial begin
    bit hs;
    s_tvalid = 1'b0;
    s_tdata  = 48'h0;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_tvalid && s_tready && !reset;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      s_tvalid = (src_q.size() > 0);
      s_tdata  = s_tvalid ? src_q[0] : 48'h0;
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500 us");
    $fatal(1);
  end

  task automatic push_samples(input logic [47:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) src_q.push_back(base + 48'(k));
  endtask

  task automatic get_frame(input string name);
    bit ok;
    int pos;
    beat_t b;
    ok = 1'b0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      pos = -1;
      foreach (cap_q[i]) if (cap_q[i].l && pos < 0) pos = i;
      if (pos >= 0 && pos < 300) begin
        fr_len = pos + 1;
        for (int i = 0; i <= pos; i++) begin
          b = cap_q.pop_front();
          fr_d[i] = b.d;
          fr_l[i] = b.l;
        end
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      fr_len = 0;
      $display("FAIL %s_timeout: got no tlast expected a frame within 4000 cycles", name);
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] seq, input logic [47:0] base);
    int bad;
    int first;
    bad = 0;
    first = -1;
    chk({name, "_len"}, 64'(fr_len), 64'd64);
    for (int i = 0; i < fr_len && i < 64; i++) begin
      if (fr_d[i] !== exp_byte(i, seq, base) || fr_l[i] !== (i == 63)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_bytes: got B%0d=%02h last=%0b expected %02h last=%0b (%0d bad bytes)",
               name, first, fr_d[first], fr_l[first], exp_byte(first, seq, base), (first == 63), bad);
    end
  endtask

  initial begin
    vecs[0]  = '{0,  8'hFF, 1'b0};
    vecs[1]  = '{5,  8'hFF, 1'b0};
    vecs[2]  = '{6,  8'h02, 1'b0};
    vecs[3]  = '{7,  8'h00, 1'b0};
    vecs[4]  = '{11, 8'h01, 1'b0};
    vecs[5]  = '{12, 8'h88, 1'b0};
    vecs[6]  = '{13, 8'hB5, 1'b0};
    vecs[7]  = '{14, 8'h00, 1'b0};
    vecs[8]  = '{15, 8'h00, 1'b0};
    vecs[9]  = '{16, 8'h01, 1'b0};
    vecs[10] = '{21, 8'h06, 1'b0};
    vecs[11] = '{22, 8'h02, 1'b0};
    vecs[12] = '{58, 8'h08, 1'b0};
    vecs[13] = '{63, 8'h06, 1'b1};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_tdata),  64'd0);
    chk("rst_m_tkeep",  64'(m_tkeep),  64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Three back-to-back frames, sink always ready.
    @(negedge clk);
    push_samples(BASE0, 0, 7);
    push_samples(BASE1, 0, 7);
    push_samples(BASE2, 0, 7);
    get_frame("f0");
    for (int i = 0; i < 14; i++)
      chk($sformatf("vec%0d_B%0d", i, vecs[i].idx), 64'({fr_d[vecs[i].idx], fr_l[vecs[i].idx]}),
          64'({vecs[i].d, vecs[i].l}));
    check_frame("f0", 16'h0000, BASE0);
    get_frame("f1");
    check_frame("f1", 16'h0001, BASE1);
    get_frame("f2");
    check_frame("f2", 16'h0002, BASE2);

    // Sequence wrap from 16'hFFFF.
    repeat (5) @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    push_samples(BASE1, 0, 7);
    push_samples(BASE2, 0, 7);
    get_frame("f3");
    check_frame("f3", 16'hFFFF, BASE1);
    get_frame("f4");
    check_frame("f4", 16'h0000, BASE2);

    // Random sink backpressure.
    rdy_rand = 1'b1;
    stalls = 0;
    push_samples(BASE0, 0, 7);
    get_frame("f5");
    check_frame("f5", 16'h0001, BASE0);
    rdy_rand = 1'b0;
    chk("stalls_seen", 64'(stalls > 0), 64'd1);

    // Source runs dry after the third sample.
    repeat (3) @(negedge clk);
    push_samples(BASE3, 0, 2);
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
        @(negedge clk);
        found = s_tready && (src_q.size() == 0);
      end
      chk("load_reached", 64'(found), 64'd1);
    end
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("load_wait%0d", c), 64'({m_tvalid, s_tready}), 64'b01);
      @(negedge clk);
    end
    push_samples(BASE3, 3, 7);
    get_frame("f6");
    check_frame("f6", 16'h0002, BASE3);

    // Reset while byte 30 is presented.
    repeat (3) @(negedge clk);
    cap_q.delete();
    push_samples(BASE1, 0, 7);
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
        @(negedge clk);
        #2;
        found = (cap_q.size() == 31);
      end
      chk("byte30_reached", 64'(found), 64'd1);
    end
    reset = 1'b1;
    src_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    cap_q.delete();
    push_samples(BASE2, 0, 7);
    get_frame("f7");
    check_frame("f7", 16'h0000, BASE2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
